// File: rtl/output_pkg.sv
// Shared types and sizing helpers for the output store stage.
package output_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int unsigned lanes_of(input int unsigned bus_w, input int unsigned data_w);
    return bus_w / data_w;
  endfunction

  // Lane index width; at least one bit so single-lane builds still have a counter.
  function automatic int unsigned lane_idx_w(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/output_word_reg.sv
// Single-entry output holding register with valid/ready release; reusable by pipeline stores.
module output_word_reg #(
  parameter int unsigned PAYLOAD_W = 128,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [PAYLOAD_W-1:0] load_payload,
  input  logic [ADDR_W-1:0]    load_addr,
  input  logic                 ready,
  output logic                 valid,
  output logic [PAYLOAD_W-1:0] payload,
  output logic [ADDR_W-1:0]    addr,
  output logic                 free_c
);

  // The slot can take a new word when empty or when the held word leaves this edge.
  assign free_c = !valid || ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid   <= 1'b0;
      payload <= '0;
      addr    <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      payload <= load_payload;
      addr    <= load_addr;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/output_packer.sv
// Packs DATA_W-bit results MSB-first into BUS_W-bit memory words with base-relative addressing.
// Optional byte strobe output enabled by defining OUTPUT_PACKER_STRB_EN.
module output_packer
  import output_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BUS_W  = 128,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [BUS_W-1:0]    wr_data,
  output logic [ADDR_W-1:0]   wr_addr,
`ifdef OUTPUT_PACKER_STRB_EN
  output logic [BUS_W/8-1:0]  wr_strb,
`endif
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   word_count
);

  localparam int unsigned LANES  = lanes_of(BUS_W, DATA_W);
  localparam int unsigned LANE_W = lane_idx_w(LANES);
`ifdef OUTPUT_PACKER_STRB_EN
  localparam int unsigned STRB_W = BUS_W / 8;
  localparam int unsigned PAY_W  = BUS_W + STRB_W;
`else
  localparam int unsigned PAY_W  = BUS_W;
`endif

  state_t             state, state_nxt;
  logic [LANE_W-1:0]  lane, lane_nxt;
  logic [BUS_W-1:0]   pack, pack_nxt;
  logic [ADDR_W-1:0]  next_addr, next_addr_nxt;
  logic [ADDR_W-1:0]  word_count_nxt;
  logic               busy_nxt, done_nxt;
  logic               closing_c, accept_c, load_c, free_c;
  logic [BUS_W-1:0]   word_c;
  logic [PAY_W-1:0]   payload_c, payload_q;
`ifdef OUTPUT_PACKER_STRB_EN
  logic [STRB_W-1:0]  strb_c;
  int unsigned        filled_c;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      lane       <= '0;
      pack       <= '0;
      next_addr  <= '0;
      word_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      lane       <= lane_nxt;
      pack       <= pack_nxt;
      next_addr  <= next_addr_nxt;
      word_count <= word_count_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    lane_nxt       = lane;
    pack_nxt       = pack;
    next_addr_nxt  = next_addr;
    word_count_nxt = word_count;
    load_c         = 1'b0;

    // A closing element may only enter when the output slot can take the finished word.
    closing_c = (lane == LANE_W'(LANES - 1)) || in_last;
    in_ready  = (state == FILL) && (!closing_c || free_c);
    accept_c  = in_valid && in_ready;

    word_c = pack;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane == LANE_W'(i)) word_c[BUS_W-1-i*DATA_W -: DATA_W] = in_data;
    end

    if (wr_valid && wr_ready) word_count_nxt = word_count + ADDR_W'(1);

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt      = FILL;
          lane_nxt       = '0;
          pack_nxt       = '0;
          next_addr_nxt  = base_addr;
          word_count_nxt = '0;
        end
      end
      FILL: begin
        if (accept_c) begin
          if (closing_c) begin
            load_c        = 1'b1;
            pack_nxt      = '0;
            lane_nxt      = '0;
            next_addr_nxt = next_addr + ADDR_W'(1);
            if (in_last) state_nxt = DRAIN;
          end else begin
            pack_nxt = word_c;
            lane_nxt = lane + LANE_W'(1);
          end
        end
      end
      DRAIN: begin
        if (wr_valid && wr_ready) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == FILL) || (state_nxt == DRAIN);
    done_nxt = (state_nxt == DONE);
  end

`ifdef OUTPUT_PACKER_STRB_EN
  // Strobe covers the bytes of every lane filled so far, MSB-aligned.
  always_comb begin
    filled_c = 32'(lane) + 32'd1;
    strb_c   = '0;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      strb_c[STRB_W-1-b] = (b < filled_c * (DATA_W / 8));
    end
  end
  assign payload_c          = {strb_c, word_c};
  assign {wr_strb, wr_data} = payload_q;
`else
  assign payload_c = word_c;
  assign wr_data   = payload_q;
`endif

  output_word_reg #(
    .PAYLOAD_W (PAY_W),
    .ADDR_W    (ADDR_W)
  ) u_word_reg (
    .clock        (clock),
    .reset        (reset),
    .load         (load_c),
    .load_payload (payload_c),
    .load_addr    (next_addr),
    .ready        (wr_ready),
    .valid        (wr_valid),
    .payload      (payload_q),
    .addr         (wr_addr),
    .free_c       (free_c)
  );

endmodule

// File: tb/tb_output_packer.sv
// Randomized self-checking bench for output_packer against a frame-level reference model.
module tb_output_packer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned BUS_W  = 128;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LANES  = BUS_W / DATA_W;
  localparam int unsigned STRB_W = BUS_W / 8;

  logic              clock;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              wr_valid;
  logic              wr_ready;
  logic [BUS_W-1:0]  wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] word_count;
`ifdef OUTPUT_PACKER_STRB_EN
  logic [STRB_W-1:0] wr_strb;
`endif

  int tests = 0;
  int fails = 0;

  output_packer #(.DATA_W(DATA_W), .BUS_W(BUS_W), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_addr    (wr_addr),
`ifdef OUTPUT_PACKER_STRB_EN
    .wr_strb    (wr_strb),
`endif
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_in_ready"}, BUS_W'(in_ready), '0);
    chk({tag, "_wr_valid"}, BUS_W'(wr_valid), '0);
    chk({tag, "_busy"}, BUS_W'(busy), '0);
    chk({tag, "_done"}, BUS_W'(done), '0);
    chk({tag, "_wr_data"}, wr_data, '0);
    chk({tag, "_wr_addr"}, BUS_W'(wr_addr), '0);
    chk({tag, "_word_count"}, BUS_W'(word_count), '0);
`ifdef OUTPUT_PACKER_STRB_EN
    chk({tag, "_wr_strb"}, BUS_W'(wr_strb), '0);
`endif
  endtask

  // mode 0: full rate; mode 1: random valid/ready; mode 2: wr_ready low for 20 cycles
  task automatic run_frame(input logic [ADDR_W-1:0] base, input int n, input int mode,
                           input bit seq, input bit bogus);
    logic [DATA_W-1:0] el[$];
    logic [BUS_W-1:0]  exp_d[$];
    logic [ADDR_W-1:0] exp_a[$];
`ifdef OUTPUT_PACKER_STRB_EN
    logic [STRB_W-1:0] exp_s[$];
`endif
    logic [BUS_W-1:0]  w;
    int nw, idx, wr_idx, cyc;
    bit in_fill, pending, done_exp, done_nxt, finished, closing, exp_rdy, acc, fire;

    for (int i = 0; i < n; i++) el.push_back(seq ? DATA_W'(i) : DATA_W'($urandom));
    nw = (n + LANES - 1) / LANES;
    for (int j = 0; j < nw; j++) begin
      int f;
      f = (n - j * LANES < LANES) ? n - j * LANES : LANES;
      w = '0;
      for (int k = 0; k < f; k++) w = w | (BUS_W'(el[j * LANES + k]) << (BUS_W - DATA_W * (k + 1)));
      exp_d.push_back(w);
      exp_a.push_back(ADDR_W'(base + ADDR_W'(j)));
`ifdef OUTPUT_PACKER_STRB_EN
      exp_s.push_back(STRB_W'({STRB_W{1'b1}} << (STRB_W - f * DATA_W / 8)));
`endif
    end

    @(negedge clock);
    start = 1'b1; base_addr = base; in_valid = 1'b0; in_last = 1'b0; wr_ready = 1'b1;
    @(negedge clock);
    idx = 0; wr_idx = 0; cyc = 0;
    in_fill = 1'b1; pending = 1'b0; done_exp = 1'b0; done_nxt = 1'b0; finished = 1'b0;

    while (!finished && cyc < 2000) begin
      start     = bogus && (cyc == 5);
      base_addr = start ? 16'hABCD : base;
      in_valid  = in_fill && ((mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_data   = in_valid ? el[idx] : '0;
      in_last   = in_valid && (idx == n - 1);
      case (mode)
        0:       wr_ready = 1'b1;
        1:       wr_ready = ($urandom_range(0, 2) != 0);
        default: wr_ready = !(cyc >= 16 && cyc < 36);
      endcase
      #1;
      closing = ((idx % LANES) == LANES - 1) || (idx == n - 1);
      exp_rdy = in_fill && !(closing && pending && !wr_ready);
      chk("in_ready", BUS_W'(in_ready), BUS_W'(exp_rdy));
      chk("wr_valid", BUS_W'(wr_valid), BUS_W'(pending));
      chk("done", BUS_W'(done), BUS_W'(done_exp));
      chk("busy", BUS_W'(busy), BUS_W'(!done_exp));
      chk("word_count", BUS_W'(word_count), BUS_W'(wr_idx));
      if (pending) begin
        chk("wr_data", wr_data, exp_d[wr_idx]);
        chk("wr_addr", BUS_W'(wr_addr), BUS_W'(exp_a[wr_idx]));
`ifdef OUTPUT_PACKER_STRB_EN
        chk("wr_strb", BUS_W'(wr_strb), BUS_W'(exp_s[wr_idx]));
`endif
      end
      if (done_exp) begin
        chk("words_written", BUS_W'(wr_idx), BUS_W'(nw));
        finished = 1'b1;
      end else begin
        acc  = in_valid && exp_rdy;
        fire = pending && wr_ready;
        if (fire) begin
          wr_idx++;
          if (wr_idx == nw) done_nxt = 1'b1;
        end
        pending = (acc && closing) ? 1'b1 : (fire ? 1'b0 : pending);
        if (acc) begin
          idx++;
          if (idx == n) in_fill = 1'b0;
        end
        done_exp = done_nxt;
        cyc++;
        @(negedge clock);
      end
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("frame_completed", BUS_W'(finished), BUS_W'(1));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_data = '0; in_last = 1'b0; wr_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk_idle_zero("reset");
    reset = 1'b0;

    run_frame(16'h0100, 32, 0, 1'b1, 1'b0);
    run_frame(16'h0200, 19, 0, 1'b1, 1'b0);
    run_frame(16'h0400, 48, 2, 1'b0, 1'b0);
    run_frame(16'hFFFF, 32, 0, 1'b0, 1'b0);

    // Abandon a frame after 7 elements with a reset pulse.
    @(negedge clock);
    start = 1'b1; base_addr = 16'h0200; wr_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = DATA_W'($urandom | 1); in_last = 1'b0;
      @(negedge clock);
    end
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    chk_idle_zero("mid_reset");
    reset = 1'b0;

    run_frame(16'h0300, 16, 0, 1'b0, 1'b0);
    run_frame(16'h0500, 40, 0, 1'b0, 1'b1);
    for (int r = 0; r < 5; r++) run_frame(ADDR_W'($urandom), $urandom_range(1, 50), 1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/output_packer.md
Name: output_packer

Overview:
- Parametrised successor to the single-channel output store stage at the end of the output pipeline.
- Accepts a stream of DATA_W-bit results over a valid/ready handshake and packs them into BUS_W-bit memory words.
- Issues each word to the output memory port with valid/ready backpressure, a base-relative incrementing address, and partial-word flush on end of frame.

Parameters:
- DATA_W, 8, width of one result element
- BUS_W, 128, write word width; must be an integer multiple of DATA_W (LANES = BUS_W/DATA_W)
- ADDR_W, 16, write address width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin frame, latch base_addr
- base_addr  in  ADDR_W  first word address of the frame
- in_valid  in  1  result element valid
- in_ready  out  1  element accepted when in_valid && in_ready
- in_data  in  DATA_W  result element
- in_last  in  1  qualifies the final element of the frame
- wr_valid  out  1  write word pending
- wr_ready  in  1  memory accepts the word when wr_valid && wr_ready
- wr_data  out  BUS_W  packed word
- wr_addr  out  ADDR_W  word address
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the final word is accepted
- word_count  out  ADDR_W  words accepted by memory in the current or last frame

Behaviour:
- Reset: state IDLE; in_ready, wr_valid, busy, done = 0; wr_data, wr_addr, word_count, lane index, pack register = 0.
- States: IDLE -> (start) FILL -> (last element packed) DRAIN -> (final word accepted) DONE -> IDLE after one cycle. DONE is the cycle in which done = 1.
- start is honoured only in IDLE and ignored in all other states. In IDLE: lane = 0, pack register = 0, next address = base_addr, word_count = 0.
- Lane order: the first element of a word occupies the most-significant lane, bits [BUS_W-1 : BUS_W-DATA_W]. Element k occupies lane k counted from the MSB.
- Pack register and output register (wr_data/wr_addr/wr_valid) are separate.
  - A full word, or a partial word closed by in_last, moves to the output register in the same edge that accepts its last element.
  - The pack register then clears and lane resets to 0.
- Unfilled lanes of a partial word are 0.
- in_ready = (state == FILL) && !(closing element && wr_valid && !wr_ready). An element is "closing" when lane == LANES-1 or in_last = 1. in_ready depends combinationally on wr_ready.
- Sustained throughput: one element per clock with wr_ready held high. No bubble at word boundaries.
- wr_valid rises the cycle after the word is loaded and holds, with wr_data and wr_addr stable, until wr_ready.
- wr_addr = base_addr + word index, computed modulo 2^ADDR_W. Wrap past all-ones to 0 is silent.
- word_count increments on each accepted write and wraps identically.
- in_last on lane LANES-1 produces one full word with no extra empty word.
- A frame with no elements is not possible: in_last always accompanies an element.
- done fires only after wr_ready accepts the final word. busy drops in the same cycle done rises.
- Reset asserted mid-frame discards the pack register and the pending word, and returns all outputs to reset values on the next edge.

Optional Feature:
- Macro: OUTPUT_PACKER_STRB_EN
- Defined: adds output port wr_strb [BUS_W/8-1:0] (requires DATA_W a multiple of 8). One bit per byte; a bit is 1 for bytes belonging to filled lanes. MSB-aligned, so a partial word of 3 lanes with DATA_W = 8 gives 16'hE000. Full words give all ones. Reset value 0. Held stable with wr_data.
- Undefined: no port. Unfilled lanes are still zero-filled.

Decomposition:
- Shared package output_pkg holds:
  - state enum (IDLE, FILL, DRAIN, DONE)
  - LANES derivation function
  - lane index width constant
- One natural sub-module: output_word_reg. It is the single-entry output holding register with the valid/ready handshake (load, hold, and release of data, address and strobe), and is reusable by other pipeline stores.
- The packer FSM, lane counter and address generator stay in the top module.

Test Plan:
- Defaults, base_addr = 16'h0100, 32 elements 8'h00..8'h1F, in_last on the last element, wr_ready = 1 -> two writes:
  - 0x000102..0F at addr 0x0100
  - 0x101112..1F at addr 0x0101
  - in_ready never low; done one cycle after the second write; word_count = 2.
- 19 elements, in_last on the 19th -> second word = 0x10,0x11,0x12 followed by 13 zero bytes; strobe 16'hE000 with OUTPUT_PACKER_STRB_EN; done after acceptance.
- wr_ready low for 20 cycles during a 48-element stream -> in_ready drops only on closing elements while wr_valid is pending; no element lost or duplicated; wr_data and wr_addr stable while stalled.
- base_addr = 16'hFFFF, 32 elements -> addresses 0xFFFF then 0x0000.
- Reset pulsed mid-frame after 7 elements -> all outputs return to 0 next edge. A new start with 16 elements produces exactly one word at the new base_addr, with no residue of the old frame.
- start pulsed while busy -> ignored; base address and count unchanged.
